// File: rtl/playback_pkg.sv
// Shared types for the playback burst sequencer: FSM states, trigger source
// encodings and the trigger-select helper.
package playback_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      DELAY = 3'd2,
      START = 3'd3,
      PLAY  = 3'd4,
      GAP   = 3'd5,
      DONE  = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      TRIG_SW       = 2'd0,
      TRIG_EXT_RISE = 2'd1,
      TRIG_EXT_FALL = 2'd2,
      TRIG_IMM      = 2'd3
   } trig_src_e;

   localparam int CNT_W = 32;

   // Selected trigger source fired this cycle; TRIG_IMM fires unconditionally.
   function automatic logic trig_fired(input trig_src_e src,
                                       input logic      sw_rise,
                                       input logic      ext_rise,
                                       input logic      ext_fall);
      logic fired;
      case (src)
         TRIG_SW:       fired = sw_rise;
         TRIG_EXT_RISE: fired = ext_rise;
         TRIG_EXT_FALL: fired = ext_fall;
         TRIG_IMM:      fired = 1'b1;
         default:       fired = 1'b0;
      endcase
      return fired;
   endfunction

endpackage

// File: rtl/playback_sequencer_trig_sync.sv
// Multi-flop synchronizer for an asynchronous trigger pin, followed by
// registered single-cycle rise/fall pulses on the synchronized level.
module trig_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/playback_sequencer.sv
// Burst scheduler for the BRAM playback reader: arm, wait for a trigger,
// delay, then issue start pulses with a programmable gap between bursts.
module playback_sequencer
   import playback_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BURST_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm,
   input  logic               abort,
   input  logic [1:0]         trig_src,
   input  logic               sw_trig,
   input  logic               ext_trig,
   input  logic [31:0]        trig_delay,
   input  logic [BURST_W-1:0] n_bursts,
   input  logic [31:0]        gap_cycles,
   output logic               play_en,
   input  logic               play_finish,
   output logic               busy,
   output logic               waiting_trig,
   output logic               done,
   output logic [BURST_W-1:0] burst_count
);

   state_e             state_q, state_d;
   logic               arm_prev_q, sw_prev_q, fin_prev_q;
   trig_src_e          trig_src_q, trig_src_d;
   logic [CNT_W-1:0]   trig_delay_q, trig_delay_d;
   logic [CNT_W-1:0]   gap_cycles_q, gap_cycles_d;
   logic [BURST_W-1:0] n_bursts_q, n_bursts_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0] burst_count_q, burst_count_d;
   logic               play_en_q, play_en_d;
   logic               busy_q, busy_d;
   logic               waiting_q, waiting_d;
   logic               done_q, done_d;

   logic arm_rise, sw_rise, fin_rise;
   logic ext_rise, ext_fall;

   trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (ext_trig),
      .rise     (ext_rise),
      .fall     (ext_fall)
   );

   // play_finish is high whenever the reader is idle, so only its edge matters.
   assign arm_rise = arm & ~arm_prev_q;
   assign sw_rise  = sw_trig & ~sw_prev_q;
   assign fin_rise = play_finish & ~fin_prev_q;

   always_comb begin
      state_d       = state_q;
      trig_src_d    = trig_src_q;
      trig_delay_d  = trig_delay_q;
      gap_cycles_d  = gap_cycles_q;
      n_bursts_d    = n_bursts_q;
      cnt_d         = cnt_q;
      burst_count_d = burst_count_q;

      case (state_q)
         IDLE: begin
            if (arm_rise) begin
               trig_src_d    = trig_src_e'(trig_src);
               trig_delay_d  = trig_delay;
               gap_cycles_d  = gap_cycles;
               n_bursts_d    = n_bursts;
               burst_count_d = '0;
               state_d       = ARMED;
            end
         end
         ARMED: begin
            if (trig_fired(trig_src_q, sw_rise, ext_rise, ext_fall)) begin
               if (trig_delay_q != '0) begin
                  cnt_d   = 32'd1;
                  state_d = DELAY;
               end else begin
                  state_d = START;
               end
            end
         end
         // Counting from 1 up to the latched value avoids wrap at 0xFFFFFFFF.
         DELAY: begin
            if (cnt_q == trig_delay_q) state_d = START;
            else                       cnt_d   = cnt_q + 32'd1;
         end
         START: state_d = PLAY;
         PLAY: begin
            if (fin_rise) begin
               burst_count_d = burst_count_q + BURST_W'(1);
               if ((n_bursts_q != '0) && (burst_count_d == n_bursts_q)) begin
                  state_d = DONE;
               end else if (gap_cycles_q == '0) begin
                  state_d = START;
               end else begin
                  cnt_d   = 32'd1;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (cnt_q == gap_cycles_q) state_d = START;
            else                       cnt_d   = cnt_q + 32'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides any arm, trigger or finish event seen this cycle.
      if (abort) begin
         state_d       = IDLE;
         trig_src_d    = trig_src_q;
         trig_delay_d  = trig_delay_q;
         gap_cycles_d  = gap_cycles_q;
         n_bursts_d    = n_bursts_q;
         burst_count_d = burst_count_q;
      end

      play_en_d = (state_d == START);
      busy_d    = (state_d != IDLE);
      waiting_d = (state_d == ARMED);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         arm_prev_q    <= 1'b0;
         sw_prev_q     <= 1'b0;
         fin_prev_q    <= 1'b0;
         trig_src_q    <= TRIG_SW;
         trig_delay_q  <= '0;
         gap_cycles_q  <= '0;
         n_bursts_q    <= '0;
         cnt_q         <= '0;
         burst_count_q <= '0;
         play_en_q     <= 1'b0;
         busy_q        <= 1'b0;
         waiting_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_prev_q    <= arm;
         sw_prev_q     <= sw_trig;
         fin_prev_q    <= play_finish;
         trig_src_q    <= trig_src_d;
         trig_delay_q  <= trig_delay_d;
         gap_cycles_q  <= gap_cycles_d;
         n_bursts_q    <= n_bursts_d;
         cnt_q         <= cnt_d;
         burst_count_q <= burst_count_d;
         play_en_q     <= play_en_d;
         busy_q        <= busy_d;
         waiting_q     <= waiting_d;
         done_q        <= done_d;
      end
   end

   assign play_en      = play_en_q;
   assign busy         = busy_q;
   assign waiting_trig = waiting_q;
   assign done         = done_q;
   assign burst_count  = burst_count_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with a behavioural reader whose
// finish flag rises 16 cycles after each start pulse.
module tb_playback_sequencer;

   logic        clk;
   logic        rst_n;
   logic        arm, abort, sw_trig, ext_trig;
   logic [1:0]  trig_src;
   logic [31:0] trig_delay, gap_cycles;
   logic [15:0] n_bursts;
   logic        play_en, play_finish, busy, waiting_trig, done;
   logic [15:0] burst_count;

   int          cyc;
   int          n_checks;
   int          n_fail;
   logic        model_en;
   int          fin_fall_at, fin_rise_at;
   logic [31:0] pe_q[$];
   logic [31:0] dn_q[$];
   int          t;

   playback_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arm          (arm),
      .abort        (abort),
      .trig_src     (trig_src),
      .sw_trig      (sw_trig),
      .ext_trig     (ext_trig),
      .trig_delay   (trig_delay),
      .n_bursts     (n_bursts),
      .gap_cycles   (gap_cycles),
      .play_en      (play_en),
      .play_finish  (play_finish),
      .busy         (busy),
      .waiting_trig (waiting_trig),
      .done         (done),
      .burst_count  (burst_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor: record the cycle number of every start and done pulse
   always @(negedge clk) begin
      if (play_en === 1'b1) pe_q.push_back(32'(cyc));
      if (done === 1'b1)    dn_q.push_back(32'(cyc));
   end

   // behavioural reader: finish drops after a start and rises 16 cycles later
   always @(negedge clk) begin
      if (model_en && play_en === 1'b1) begin
         fin_fall_at = cyc + 1;
         fin_rise_at = cyc + 16;
      end
   end

   always @(posedge clk) begin
      #1;
      if (model_en) begin
         if (cyc == fin_fall_at) play_finish = 1'b0;
         if (cyc == fin_rise_at) play_finish = 1'b1;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   task automatic clear_q();
      pe_q.delete();
      dn_q.delete();
   endtask

   initial begin
      int n;
      cyc = 0; n_checks = 0; n_fail = 0;
      fin_fall_at = -1; fin_rise_at = -1;
      model_en = 1'b1; play_finish = 1'b1;
      arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; ext_trig = 1'b0;
      trig_src = 2'd0; trig_delay = '0; gap_cycles = '0; n_bursts = '0;
      rst_n = 1'b0;
      repeat (3) tick();

      check("rst play_en", 32'(play_en), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst waiting", 32'(waiting_trig), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst burst_count", 32'(burst_count), 32'd0);
      rst_n = 1'b1;
      tick(); tick();
      check("post-rst busy", 32'(busy), 32'd0);

      // single burst, software trigger
      clear_q();
      trig_src = 2'd0; n_bursts = 16'd1; trig_delay = 32'd0; gap_cycles = 32'd0;
      do_arm();
      check("t1 waiting", 32'(waiting_trig), 32'd1);
      check("t1 busy", 32'(busy), 32'd1);
      tick(); sw_trig = 1'b1; t = cyc;
      tick(); sw_trig = 1'b0;
      wait_idle(100, "t1");
      check("t1 n_play", 32'(pe_q.size()), 32'd1);
      check("t1 play cyc", pe_q[0], 32'(t + 1));
      check("t1 n_done", 32'(dn_q.size()), 32'd1);
      check("t1 done cyc", dn_q[0], 32'(t + 18));
      check("t1 burst_count", 32'(burst_count), 32'd1);

      // three bursts with delay 10 and gap 5
      clear_q();
      n_bursts = 16'd3; trig_delay = 32'd10; gap_cycles = 32'd5;
      do_arm();
      tick(); sw_trig = 1'b1; t = cyc;
      tick(); sw_trig = 1'b0;
      wait_idle(200, "t2");
      check("t2 n_play", 32'(pe_q.size()), 32'd3);
      check("t2 play0", pe_q[0], 32'(t + 11));
      check("t2 play1", pe_q[1], 32'(t + 33));
      check("t2 play2", pe_q[2], 32'(t + 55));
      check("t2 n_done", 32'(dn_q.size()), 32'd1);
      check("t2 done cyc", dn_q[0], 32'(t + 72));
      check("t2 burst_count", 32'(burst_count), 32'd3);

      // external falling trigger; a rising edge alone starts nothing
      clear_q();
      trig_src = 2'd2; n_bursts = 16'd1; trig_delay = 32'd0; gap_cycles = 32'd0;
      do_arm();
      tick(); ext_trig = 1'b1;
      repeat (10) tick();
      check("t3 rise no play", 32'(pe_q.size()), 32'd0);
      check("t3 still armed", 32'(waiting_trig), 32'd1);
      ext_trig = 1'b0; t = cyc;
      wait_idle(100, "t3");
      check("t3 n_play", 32'(pe_q.size()), 32'd1);
      check("t3 play cyc", pe_q[0], 32'(t + 4));
      check("t3 burst_count", 32'(burst_count), 32'd1);

      // infinite mode, abort after five bursts
      clear_q();
      trig_src = 2'd3; n_bursts = 16'd0; gap_cycles = 32'd2;
      do_arm();
      n = 0;
      while (burst_count != 16'd5 && n < 300) begin
         tick();
         n++;
      end
      check("t4 reached 5", 32'(burst_count), 32'd5);
      tick(); abort = 1'b1;
      tick();
      check("t4 abort busy", 32'(busy), 32'd0);
      check("t4 abort play_en", 32'(play_en), 32'd0);
      check("t4 abort count", 32'(burst_count), 32'd5);
      check("t4 n_play", 32'(pe_q.size()), 32'd5);
      check("t4 no done", 32'(dn_q.size()), 32'd0);
      abort = 1'b0;
      do_arm();
      check("t4 rearm clears", 32'(burst_count), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

      // ignored events
      model_en = 1'b0;
      play_finish = 1'b0;
      clear_q();
      tick(); sw_trig = 1'b1;
      tick(); sw_trig = 1'b0;
      tick(); play_finish = 1'b1;
      tick(); tick();
      check("t5 idle sw busy", 32'(busy), 32'd0);
      check("t5 idle sw play", 32'(pe_q.size()), 32'd0);
      check("t5 idle fin count", 32'(burst_count), 32'd0);
      trig_src = 2'd0; n_bursts = 16'd2; trig_delay = 32'd0; gap_cycles = 32'd0;
      do_arm();
      play_finish = 1'b0;
      tick(); play_finish = 1'b1;
      tick(); tick();
      check("t5 armed fin count", 32'(burst_count), 32'd0);
      check("t5 armed waiting", 32'(waiting_trig), 32'd1);
      model_en = 1'b1;
      clear_q();
      tick(); sw_trig = 1'b1; t = cyc;
      tick(); sw_trig = 1'b0;
      tick(); tick();
      arm = 1'b1; n_bursts = 16'd1; gap_cycles = 32'd50; trig_src = 2'd3; trig_delay = 32'd7;
      tick();
      wait_idle(150, "t5");
      arm = 1'b0;
      check("t5 n_play", 32'(pe_q.size()), 32'd2);
      check("t5 play0", pe_q[0], 32'(t + 1));
      check("t5 play1", pe_q[1], 32'(t + 18));
      check("t5 n_done", 32'(dn_q.size()), 32'd1);
      check("t5 done cyc", dn_q[0], 32'(t + 35));
      check("t5 burst_count", 32'(burst_count), 32'd2);

      // maximum trigger delay must not wrap early
      clear_q();
      tick();
      trig_src = 2'd3; trig_delay = 32'hFFFF_FFFF; n_bursts = 16'd1; gap_cycles = 32'd0;
      do_arm();
      repeat (40) tick();
      check("t6 no early play", 32'(pe_q.size()), 32'd0);
      check("t6 busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick(); abort = 1'b0;
      tick();
      check("t6 abort busy", 32'(busy), 32'd0);

      // async reset while playing
      clear_q();
      trig_delay = 32'd0; n_bursts = 16'd0; gap_cycles = 32'd0; trig_src = 2'd3;
      do_arm();
      n = 0;
      while (burst_count != 16'd2 && n < 100) begin
         tick();
         n++;
      end
      check("t7 reached 2", 32'(burst_count), 32'd2);
      check("t7 restart play_en", 32'(play_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t7 rst play_en", 32'(play_en), 32'd0);
      check("t7 rst busy", 32'(busy), 32'd0);
      check("t7 rst count", 32'(burst_count), 32'd0);
      check("t7 rst waiting", 32'(waiting_trig), 32'd0);
      #3 rst_n = 1'b1;
      clear_q();
      repeat (10) tick();
      check("t7 no play after rst", 32'(pe_q.size()), 32'd0);
      check("t7 idle after rst", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
Burst scheduler for the signal-generator BRAM playback reader.
- Arms on software command and waits for a selectable trigger, then applies a trigger delay.
- Issues single-cycle start pulses to the reader's `en` input, counts completed bursts via the reader's `finish` flag, and inserts a programmable gap between bursts.
- Sits between the AXI/register config block and the playback reader; reports busy, armed and done status back to registers.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `ext_trig` synchronizer (minimum 2).
- BURST_W, 16, width of the burst counter and `n_bursts`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level; rising edge in IDLE arms the sequencer and latches config
- abort  in  1  level; synchronous abort to IDLE, priority over all else
- trig_src  in  2  0=software, 1=ext rising, 2=ext falling, 3=immediate
- sw_trig  in  1  software trigger, rising-edge detected
- ext_trig  in  1  asynchronous external trigger pin
- trig_delay  in  32  cycles from trigger acceptance to first start
- n_bursts  in  BURST_W  bursts per arm; 0 = infinite until abort
- gap_cycles  in  32  idle cycles between `finish` edge and next start
- play_en  out  1  to reader `en`; one-cycle start pulse
- play_finish  in  1  from reader `finish` (level; stays high while reader idle)
- busy  out  1  high in every state except IDLE
- waiting_trig  out  1  high in ARMED
- done  out  1  one-cycle pulse on normal completion
- burst_count  out  BURST_W  bursts completed since last arm

Behaviour:
- Reset (`rst_n`=0, async): state=IDLE, all outputs 0, all counters and edge registers 0.
- All outputs are registered.
- Config (`trig_src`, `trig_delay`, `n_bursts`, `gap_cycles`) is latched on arm acceptance. Changes while busy are ignored.
- Edge detection:
  - `arm` and `sw_trig` use an internal previous-value register.
  - `ext_trig` passes through SYNC_STAGES flops before edge detection, giving 2+1 cycles latency.
  - `play_finish` uses a rising-edge detect only; its level is never used, because it is high while the reader is idle.
- States:
  - IDLE: on `arm` rising edge, latch config, clear `burst_count`, go to ARMED. `arm` edges outside IDLE are ignored.
  - ARMED: accept a trigger when the selected source fires. Source 3 fires in the first ARMED cycle. Go to DELAY if `trig_delay`!=0, else START.
  - DELAY: count `trig_delay` cycles, then START. For trigger accepted at cycle t, `play_en` is high exactly at cycle t+1+`trig_delay`.
  - START: `play_en`=1 for exactly one cycle, then PLAY.
  - PLAY: wait for `play_finish` rising edge; on that cycle `burst_count`++.
    - If `n_bursts`!=0 and new count == `n_bursts`: go to DONE.
    - Else if `gap_cycles`==0: go to START.
    - Else: go to GAP.
  - GAP: count `gap_cycles` cycles, then START. `play_en` rises `gap_cycles`+1 cycles after the finish edge cycle.
  - DONE: `done`=1 for one cycle, then IDLE. `burst_count` holds its value until the next arm.
- `play_en` is low in at least one cycle between consecutive starts, so the reader sees a fresh rising edge.
- Abort: any state goes to IDLE on the next edge.
  - `play_en` is forced 0 and no `done` pulse is issued.
  - `burst_count` holds its value.
  - Abort wins over a simultaneous finish edge, trigger, or `arm` edge.
- Infinite mode (`n_bursts`=0): `burst_count` wraps modulo 2^BURST_W. The sequencer never reaches DONE.
- Triggers arriving outside ARMED are dropped, not queued.
- Counters are unsigned 32-bit compare-to-latched-value. `trig_delay` or `gap_cycles` = 0xFFFFFFFF is legal and does not wrap early.
- A `play_finish` rising edge outside PLAY is ignored.

Decomposition:
- Package `playback_pkg`:
  - State enum: IDLE, ARMED, DELAY, START, PLAY, GAP, DONE.
  - `trig_src` encodings: TRIG_SW, TRIG_EXT_RISE, TRIG_EXT_FALL, TRIG_IMM.
- One sub-module, `trig_sync`: parameterised SYNC_STAGES synchronizer with registered rise/fall pulse outputs, used for `ext_trig`.

Test Plan:
- Sources: reader instance with ADDR_WIDTH=4, `dec_rate`=0 (finish edge 16 cycles after `play_en`), or a behavioural finish model.
- Single burst, software trigger: `trig_src`=0, `n_bursts`=1, `trig_delay`=0, `gap_cycles`=0; `arm` edge, then `sw_trig` edge at t -> `play_en` at t+1 only; `done` pulse one cycle after finish edge; `burst_count`=1; `busy` returns 0.
- Multi-burst with gap: `n_bursts`=3, `gap_cycles`=5, `trig_delay`=10 -> first `play_en` at t+11; subsequent `play_en` 6 cycles after each finish edge; exactly 3 `play_en` pulses; `done` once; `burst_count`=3.
- External falling trigger: `trig_src`=2; `ext_trig` glitch-free 1->0 at t -> `play_en` at t+3(sync+edge)+1. A rising edge alone produces no start.
- Infinite mode and abort: `n_bursts`=0, `trig_src`=3; after 5 finish edges assert `abort` -> next cycle IDLE, `play_en`=0, no `done`, `burst_count`=5. A subsequent `arm` clears the count to 0.
- Ignored events: `sw_trig` before `arm` -> nothing. `arm` edge during PLAY -> no restart. Config change mid-run -> no effect. `play_finish` high in IDLE/ARMED -> no count.
- Async reset mid-PLAY: drop `rst_n` between clock edges -> outputs 0 immediately (no clock needed); after release, state=IDLE and `play_en` stays 0 until re-armed.
